viterbi_seq_ctrl: RTL and testbench



---
 rtl/viterbi_pkg.sv | 19 +
 rtl/viterbi_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_viterbi_seq_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi decoder frame sequencer and its datapath.
package viterbi_pkg;

    localparam int unsigned FRAME_LEN_DEFAULT = 256;

    // Received encoded pair: bit1 first-coded, bit0 second-coded.
    typedef logic [1:0] rx_pair_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ACCUM,
        FLUSH,
        TB,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/viterbi_seq_ctrl.sv
// Frame sequencer for the Viterbi decoder: accepts symbol pairs, strobes ACS/survivor writes,
// then walks the survivor memory backwards and tags each decoded bit.
module viterbi_seq_ctrl
    import viterbi_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = FRAME_LEN_DEFAULT,
    localparam int unsigned AW        = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sym_valid,
    output logic          sym_ready,
    input  rx_pair_t      sym_pair,
    output rx_pair_t      rx_pair,
    output logic          acs_init,
    output logic          acs_en,
    output logic          surv_we,
    output logic [AW-1:0] surv_waddr,
    output logic          tb_start,
    output logic          tb_re,
    output logic [AW-1:0] tb_raddr,
    output logic          dec_valid,
    output logic [AW-1:0] dec_idx,
    output logic          dec_last,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    state_e        state_q;
    logic [AW-1:0] sym_cnt_q, sym_cnt_d;
    logic [AW-1:0] tb_cnt_q, tb_cnt_d;
    rx_pair_t      rx_pair_q;
    logic          acs_init_q, acs_en_q, surv_we_q;
    logic [AW-1:0] surv_waddr_q;
    logic          tb_start_q, tb_re_q;
    logic          dec_valid_q, dec_last_q;
    logic [AW-1:0] dec_idx_q;
    logic          busy_q, frame_done_q;

    always_comb begin
        sym_cnt_d = sym_cnt_q + AW'(1);
        // Decrement saturates at zero so the read column never wraps.
        tb_cnt_d  = (tb_cnt_q != '0) ? tb_cnt_q - AW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sym_cnt_q    <= '0;
            tb_cnt_q     <= '0;
            rx_pair_q    <= '0;
            acs_init_q   <= 1'b0;
            acs_en_q     <= 1'b0;
            surv_we_q    <= 1'b0;
            surv_waddr_q <= '0;
            tb_start_q   <= 1'b0;
            tb_re_q      <= 1'b0;
            dec_valid_q  <= 1'b0;
            dec_idx_q    <= '0;
            dec_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            acs_init_q   <= 1'b0;
            acs_en_q     <= 1'b0;
            surv_we_q    <= 1'b0;
            tb_start_q   <= 1'b0;
            frame_done_q <= 1'b0;

            // Traceback read data returns one cycle after the address.
            dec_valid_q  <= tb_re_q;
            dec_idx_q    <= tb_cnt_q;
            dec_last_q   <= tb_re_q && (tb_cnt_q == '0);

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= INIT;
                        acs_init_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                INIT: begin
                    sym_cnt_q <= '0;
                    state_q   <= ACCUM;
                end
                ACCUM: begin
                    if (sym_valid) begin
                        rx_pair_q    <= sym_pair;
                        acs_en_q     <= 1'b1;
                        surv_we_q    <= 1'b1;
                        surv_waddr_q <= sym_cnt_q;
                        sym_cnt_q    <= sym_cnt_d;
                        if (sym_cnt_q == LAST_IDX) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    tb_cnt_q   <= LAST_IDX;
                    tb_re_q    <= 1'b1;
                    tb_start_q <= 1'b1;
                    state_q    <= TB;
                end
                TB: begin
                    tb_cnt_q <= tb_cnt_d;
                    if (tb_cnt_q == '0) begin
                        tb_re_q <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    frame_done_q <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sym_ready  = (state_q == ACCUM);
    assign rx_pair    = rx_pair_q;
    assign acs_init   = acs_init_q;
    assign acs_en     = acs_en_q;
    assign surv_we    = surv_we_q;
    assign surv_waddr = surv_waddr_q;
    assign tb_start   = tb_start_q;
    assign tb_re      = tb_re_q;
    assign tb_raddr   = tb_cnt_q;
    assign dec_valid  = dec_valid_q;
    assign dec_idx    = dec_idx_q;
    assign dec_last   = dec_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// Directed bench for viterbi_seq_ctrl at FRAME_LEN=8 and FRAME_LEN=2.
module tb_viterbi_seq_ctrl;

    typedef struct packed {
        logic       acs_init;
        logic       acs_en;
        logic       surv_we;
        logic [7:0] waddr;
        logic       tb_start;
        logic       tb_re;
        logic [7:0] raddr;
        logic       dec_valid;
        logic [7:0] idx;
        logic       dec_last;
        logic       busy;
        logic       frame_done;
        logic [1:0] rx;
        logic       sym_ready;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       start8 = 1'b0, valid8 = 1'b0, ready8;
    logic [1:0] pair8 = '0, rx8;
    logic       init8, acs8, we8, tbs8, tbre8, dv8, dl8, busy8, fd8;
    logic [2:0] waddr8, raddr8, idx8;

    logic       start2 = 1'b0, valid2 = 1'b0, ready2;
    logic [1:0] pair2 = '0, rx2;
    logic       init2, acs2, we2, tbs2, tbre2, dv2, dl2, busy2, fd2;
    logic [0:0] waddr2, raddr2, idx2;

    obs_t obs8, obs2;

    viterbi_seq_ctrl #(.FRAME_LEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sym_valid(valid8), .sym_ready(ready8),
        .sym_pair(pair8), .rx_pair(rx8), .acs_init(init8), .acs_en(acs8), .surv_we(we8),
        .surv_waddr(waddr8), .tb_start(tbs8), .tb_re(tbre8), .tb_raddr(raddr8),
        .dec_valid(dv8), .dec_idx(idx8), .dec_last(dl8), .busy(busy8), .frame_done(fd8)
    );

    viterbi_seq_ctrl #(.FRAME_LEN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sym_valid(valid2), .sym_ready(ready2),
        .sym_pair(pair2), .rx_pair(rx2), .acs_init(init2), .acs_en(acs2), .surv_we(we2),
        .surv_waddr(waddr2), .tb_start(tbs2), .tb_re(tbre2), .tb_raddr(raddr2),
        .dec_valid(dv2), .dec_idx(idx2), .dec_last(dl2), .busy(busy2), .frame_done(fd2)
    );

    always_comb begin
        obs8 = '0;
        obs8.acs_init = init8;  obs8.acs_en = acs8;   obs8.surv_we = we8;
        obs8.waddr = 8'(waddr8); obs8.tb_start = tbs8; obs8.tb_re = tbre8;
        obs8.raddr = 8'(raddr8); obs8.dec_valid = dv8; obs8.idx = 8'(idx8);
        obs8.dec_last = dl8;    obs8.busy = busy8;    obs8.frame_done = fd8;
        obs8.rx = rx8;          obs8.sym_ready = ready8;
        obs2 = '0;
        obs2.acs_init = init2;  obs2.acs_en = acs2;   obs2.surv_we = we2;
        obs2.waddr = 8'(waddr2); obs2.tb_start = tbs2; obs2.tb_re = tbre2;
        obs2.raddr = 8'(raddr2); obs2.dec_valid = dv2; obs2.idx = 8'(idx2);
        obs2.dec_last = dl2;    obs2.busy = busy2;    obs2.frame_done = fd2;
        obs2.rx = rx2;          obs2.sym_ready = ready2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input bit sel2, input logic st, input logic v, input logic [1:0] p);
        if (sel2) begin
            start2 = st; valid2 = v; pair2 = p;
        end else begin
            start8 = st; valid8 = v; pair8 = p;
        end
    endtask

    // Expected outputs at cycle c of a frame whose start was sampled at the end of cycle 0.
    // T is the first traceback cycle, last_hs the last cycle with sym_ready high.
    task automatic chk_cyc(input obs_t o, input int c, input int L, input int T, input int last_hs,
                           input bit e_acs, input int w, input int e_rx);
        chk("busy",       64'(o.busy),       64'(c >= 1 && c <= T + L + 1));
        chk("acs_init",   64'(o.acs_init),   64'(c == 1));
        chk("sym_ready",  64'(o.sym_ready),  64'(c >= 2 && c <= last_hs));
        chk("acs_en",     64'(o.acs_en),     64'(e_acs));
        chk("surv_we",    64'(o.surv_we),    64'(e_acs));
        if (e_acs) begin
            chk("surv_waddr", 64'(o.waddr), 64'(w));
            chk("rx_pair",    64'(o.rx),    64'(e_rx));
        end
        chk("tb_start",   64'(o.tb_start),   64'(c == T));
        chk("tb_re",      64'(o.tb_re),      64'(c >= T && c <= T + L - 1));
        if (c >= T && c <= T + L - 1) chk("tb_raddr", 64'(o.raddr), 64'(T + L - 1 - c));
        chk("dec_valid",  64'(o.dec_valid),  64'(c >= T + 1 && c <= T + L));
        if (c >= T + 1 && c <= T + L) chk("dec_idx", 64'(o.idx), 64'(T + L - c));
        chk("dec_last",   64'(o.dec_last),   64'(c == T + L));
        chk("frame_done", 64'(o.frame_done), 64'(c == T + L + 1));
        chk("acs_tb_excl", 64'(o.acs_en & o.tb_re), 64'(0));
    endtask

    // tog: sym_valid alternates 1,0 from the first ACCUM cycle and start is re-pulsed
    // during ACCUM and on the frame_done cycle. abort_c>0 asserts reset mid-cycle there.
    task automatic run_frame(input bit sel2, input int L, input bit tog, input int abort_c);
        int T, last_hs, pulses, k, w, e_rx;
        bit e_acs;
        obs_t o;
        logic v, st;
        logic [1:0] p;
        T       = tog ? 2 * L + 2 : L + 3;
        last_hs = tog ? 2 * L : L + 1;
        pulses  = 0;
        drive(sel2, 1'b1, !tog, 2'b00);
        for (int c = 1; c <= T + L + 3; c++) begin
            tick();
            cyc = c;
            o = sel2 ? obs2 : obs8;
            e_acs = tog ? (c % 2 == 1 && c >= 3 && c <= last_hs + 1) : (c >= 3 && c <= last_hs + 1);
            w     = tog ? (c - 3) / 2 : c - 3;
            e_rx  = tog ? 3 - (w % 4) : w % 4;
            chk_cyc(o, c, L, T, last_hs, e_acs, w, e_rx);
            if (o.acs_en) pulses++;
            if (c == abort_c) begin
                #2;
                rst_n = 1'b0;
                drive(sel2, 1'b0, 1'b0, 2'b00);
                #1;
                o = sel2 ? obs2 : obs8;
                chk("abort_outputs_zero", 64'(o), 64'(0));
                tick();
                tick();
                rst_n = 1'b1;
                return;
            end
            k  = tog ? (c - 2) / 2 : c - 2;
            v  = tog ? (c >= 2 && c % 2 == 0) : 1'b1;
            p  = (c < 2) ? 2'b00 : (tog ? 2'(3 - (k % 4)) : 2'(k % 4));
            st = tog && (c == 5 || c == T + L + 1);
            drive(sel2, st, v, p);
        end
        drive(sel2, 1'b0, 1'b0, 2'b00);
        chk("acs_pulse_count", 64'(pulses), 64'(L));
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_state_dut8", 64'(obs8), 64'(0));
        chk("reset_state_dut2", 64'(obs2), 64'(0));

        // sym_valid while idle must not be accepted
        valid8 = 1'b1; valid2 = 1'b1;
        pair8 = 2'b11; pair2 = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_ready8", 64'(ready8), 64'(0));
            chk("idle_acs8",   64'(acs8 | we8 | busy8), 64'(0));
            chk("idle_ready2", 64'(ready2), 64'(0));
            chk("idle_acs2",   64'(acs2 | we2 | busy2), 64'(0));
        end
        valid8 = 1'b0; valid2 = 1'b0;
        pair8 = 2'b00; pair2 = 2'b00;
        tick();

        run_frame(1'b0, 8, 1'b1, 0);   // toggling valid, stray starts
        run_frame(1'b0, 8, 1'b0, 0);   // continuous frame
        run_frame(1'b0, 8, 1'b0, 14);  // reset while tb_raddr==4
        tick();
        chk("post_reset_idle", 64'(obs8), 64'(0));
        run_frame(1'b0, 8, 1'b0, 0);   // clean frame after abort
        run_frame(1'b1, 2, 1'b0, 0);   // minimum frame length

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
